// File: rtl/router_slice_cb.sv
// router_slice_cb: credit-flow-controlled NoC link slice.
// Flits are queued in a DEPTH-entry circular FIFO and forwarded only while
// downstream credits remain; each forwarded flit returns one credit upstream.
// Framing, loopback, FIFO overflow and credit overflow raise a sticky ERROR.
module router_slice_cb #(
   parameter int FLIT_W       = 68,
   parameter int ADDR_W       = 4,
   parameter int DEPTH        = 4,
   parameter int DOWN_CREDITS = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [0:ADDR_W-1] ROUTER_ADDRESS,
   input  logic [0:FLIT_W-1] CHANNEL_IN_IP,
   input  logic [0:1]        FLOW_CTRL_IN_OP,
   output logic              ERROR,
   output logic [0:FLIT_W-1] CHANNEL_OUT_OP,
   output logic [0:1]        FLOW_CTRL_OUT_IP
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW = $clog2(DEPTH + 1);
   localparam int CW = $clog2(DOWN_CREDITS + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);
   localparam logic [CW-1:0] MAX_CRED = CW'(DOWN_CREDITS);

   typedef enum logic {IDLE, ACTIVE} pkt_state_e;

   logic [0:FLIT_W-1] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [NW-1:0]     count_q, count_d;
   logic [CW-1:0]     credit_q, credit_d;
   logic [0:FLIT_W-1] out_q, out_d;
   logic              fc_out_q, fc_out_d;
   logic              err_q, err_d;
   pkt_state_e        state_q, state_d;

   logic in_vld, in_head, in_tail, cred_in;
   logic enq, deq, overflow, cred_err, fsm_err, loop_err;
   logic unused_fc;

   assign in_vld    = CHANNEL_IN_IP[0];
   assign in_head   = CHANNEL_IN_IP[1];
   assign in_tail   = CHANNEL_IN_IP[2];
   assign cred_in   = FLOW_CTRL_IN_OP[0];
   assign unused_fc = FLOW_CTRL_IN_OP[1];

   // A slot freed by a same-cycle dequeue can take the incoming flit.
   assign deq      = (count_q != '0) && (credit_q != '0);
   assign overflow = in_vld && (count_q == FULL_CNT) && !deq;
   assign enq      = in_vld && !overflow;
   assign loop_err = in_vld && in_head && (CHANNEL_IN_IP[3:3+ADDR_W-1] == ROUTER_ADDRESS);

   // FIFO pointers, occupancy and credit counter next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      credit_d = credit_q;
      cred_err = 1'b0;
      if (enq) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (!enq && deq) count_d = count_q - 1'b1;
      if (deq && !cred_in) credit_d = credit_q - 1'b1;
      else if (cred_in && !deq) begin
         if (credit_q == MAX_CRED) cred_err = 1'b1;
         else                      credit_d = credit_q + 1'b1;
      end
   end

   // Packet framing FSM, evaluated on every valid input flit (dropped or not).
   always_comb begin
      state_d = state_q;
      fsm_err = 1'b0;
      if (in_vld) begin
         case (state_q)
            IDLE: begin
               if (!in_head)     fsm_err = 1'b1;
               else if (!in_tail) state_d = ACTIVE;
            end
            ACTIVE: begin
               if (in_head) begin
                  fsm_err = 1'b1;
                  state_d = in_tail ? IDLE : ACTIVE;
               end else if (in_tail) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Registered output flit / upstream credit and sticky error next-state.
   always_comb begin
      out_d    = deq ? mem_q[rd_ptr_q] : '0;
      fc_out_d = deq;
      err_d    = err_q | overflow | cred_err | fsm_err | loop_err;
   end

   // FIFO storage; contents are don't-care while the entry is not occupied.
   always_ff @(posedge clk) begin
      if (enq) mem_q[wr_ptr_q] <= CHANNEL_IN_IP;
   end

   // Control state, counters and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         credit_q <= MAX_CRED;
         out_q    <= '0;
         fc_out_q <= 1'b0;
         err_q    <= 1'b0;
         state_q  <= IDLE;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         credit_q <= credit_d;
         out_q    <= out_d;
         fc_out_q <= fc_out_d;
         err_q    <= err_d;
         state_q  <= state_d;
      end
   end

   assign CHANNEL_OUT_OP   = out_q;
   assign FLOW_CTRL_OUT_IP = {fc_out_q, 1'b0};
   assign ERROR            = err_q;

endmodule

// File: tb/tb_router_slice_cb.sv
// Directed bench for router_slice_cb with immediate-assertion checks.
module tb_router_slice_cb;

   localparam int FLIT_W = 68;
   localparam int ADDR_W = 4;
   localparam int PL_W   = FLIT_W - 3 - ADDR_W;

   logic              clk = 1'b0;
   logic              reset;
   logic [0:ADDR_W-1] router_addr;
   logic [0:FLIT_W-1] chan_in;
   logic [0:1]        fc_in;
   logic              error;
   logic [0:FLIT_W-1] chan_out;
   logic [0:1]        fc_out;

   int checks = 0;
   int errors = 0;

   logic [0:FLIT_W-1] fl [9];
   logic [0:FLIT_W-1] zf;

   router_slice_cb #(.FLIT_W(FLIT_W), .ADDR_W(ADDR_W), .DEPTH(4), .DOWN_CREDITS(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .ROUTER_ADDRESS   (router_addr),
      .CHANNEL_IN_IP    (chan_in),
      .FLOW_CTRL_IN_OP  (fc_in),
      .ERROR            (error),
      .CHANNEL_OUT_OP   (chan_out),
      .FLOW_CTRL_OUT_IP (fc_out)
   );

   always #5 clk = ~clk;

   function automatic logic [0:FLIT_W-1] mk(input logic h, input logic t,
                                            input logic [ADDR_W-1:0] d,
                                            input logic [PL_W-1:0] p);
      logic [0:FLIT_W-1] f;
      f = '0;
      f[0] = 1'b1;
      f[1] = h;
      f[2] = t;
      f[3:3+ADDR_W-1] = d;
      f[3+ADDR_W:FLIT_W-1] = p;
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_flit(input string tag, input logic [0:FLIT_W-1] obs, input logic [0:FLIT_W-1] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_bits(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Asserts reset asynchronously, checks the reset outputs, releases on a falling edge.
   task automatic do_reset(input string tag);
      chan_in = '0;
      fc_in   = '0;
      reset   = 1'b0;
      #2;
      chk_flit({tag, "_rst_out"}, chan_out, zf);
      chk_bits({tag, "_rst_fc"}, fc_out, 2'b00);
      chk_bits({tag, "_rst_err"}, {1'b0, error}, 2'b00);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      zf          = '0;
      router_addr = 4'd3;
      chan_in     = '0;
      fc_in       = '0;
      reset       = 1'b0;
      #12;

      // Single-flit packet: one-cycle latency, one-cycle credit pulse.
      do_reset("single");
      fl[0] = mk(1'b1, 1'b1, 4'd5, PL_W'(8'hA5));
      chan_in = fl[0];
      tick();
      chan_in = '0;
      chk_flit("single_lat0", chan_out, zf);
      tick();
      chk_flit("single_out", chan_out, fl[0]);
      chk_bits("single_fc", fc_out, 2'b10);
      chk_bits("single_err", {1'b0, error}, 2'b00);
      tick();
      chk_flit("single_idle", chan_out, zf);
      chk_bits("single_fc_off", fc_out, 2'b00);

      // Credit exhaustion: 6 flits, 4 credits; two more credits release the rest.
      do_reset("cred");
      for (int i = 0; i < 6; i++) fl[i] = mk(i == 0, i == 5, 4'd5, PL_W'(100 + i));
      for (int i = 0; i < 6; i++) begin
         chan_in = fl[i];
         tick();
         if (i >= 1) chk_flit($sformatf("cred_out%0d", i), chan_out, (i <= 4) ? fl[i-1] : zf);
      end
      chan_in = '0;
      tick();
      chk_flit("cred_held", chan_out, zf);
      fc_in = 2'b10;
      tick();
      fc_in = 2'b00;
      chk_flit("cred_pulse1", chan_out, zf);
      tick();
      chk_flit("cred_f5", chan_out, fl[4]);
      fc_in = 2'b10;
      tick();
      fc_in = 2'b00;
      chk_flit("cred_pulse2", chan_out, zf);
      tick();
      chk_flit("cred_f6", chan_out, fl[5]);
      chk_bits("cred_err", {1'b0, error}, 2'b00);
      tick();
      chk_flit("cred_empty", chan_out, zf);

      // Overflow: 9 flits with no credit returns; the ninth is dropped.
      do_reset("ovf");
      for (int i = 0; i < 9; i++) fl[i] = mk(i == 0, 1'b0, 4'd6, PL_W'(200 + i));
      for (int i = 0; i < 9; i++) begin
         chan_in = fl[i];
         tick();
         if (i >= 1 && i <= 4) chk_flit($sformatf("ovf_out%0d", i), chan_out, fl[i-1]);
         if (i == 7) chk_bits("ovf_err_pre", {1'b0, error}, 2'b00);
      end
      chan_in = '0;
      chk_bits("ovf_err", {1'b0, error}, 2'b01);
      fc_in = 2'b10;
      tick();
      for (int i = 4; i < 8; i++) begin
         if (i == 7) fc_in = 2'b00;
         tick();
         chk_flit($sformatf("ovf_drain%0d", i), chan_out, fl[i]);
      end
      tick();
      chk_flit("ovf_dropped", chan_out, zf);
      chk_bits("ovf_err_sticky", {1'b0, error}, 2'b01);

      // Body flit while IDLE.
      do_reset("body");
      chan_in = mk(1'b0, 1'b0, 4'd0, PL_W'(7));
      tick();
      chan_in = '0;
      chk_bits("body_idle_err", {1'b0, error}, 2'b01);

      // Head, head, tail: error at the second head.
      do_reset("hht");
      chan_in = mk(1'b1, 1'b0, 4'd5, PL_W'(1));
      tick();
      chk_bits("hht_err0", {1'b0, error}, 2'b00);
      chan_in = mk(1'b1, 1'b0, 4'd5, PL_W'(2));
      tick();
      chk_bits("hht_err1", {1'b0, error}, 2'b01);
      chan_in = mk(1'b0, 1'b1, 4'd0, PL_W'(3));
      tick();
      chan_in = '0;
      chk_bits("hht_err2", {1'b0, error}, 2'b01);

      // Credit return while the counter is full.
      do_reset("crov");
      fc_in = 2'b10;
      tick();
      fc_in = 2'b00;
      chk_bits("crov_err", {1'b0, error}, 2'b01);

      // Loopback head: error, but still forwarded.
      do_reset("loop");
      fl[0] = mk(1'b1, 1'b1, 4'd3, PL_W'(55));
      chan_in = fl[0];
      tick();
      chan_in = '0;
      chk_bits("loop_err", {1'b0, error}, 2'b01);
      tick();
      chk_flit("loop_fwd", chan_out, fl[0]);

      // Reset mid-packet with 3 flits buffered and ERROR set by a leading body flit.
      do_reset("mid");
      for (int i = 0; i < 7; i++) fl[i] = mk(1'b0, 1'b0, 4'd5, PL_W'(300 + i));
      for (int i = 0; i < 7; i++) begin
         chan_in = fl[i];
         tick();
      end
      chan_in = '0;
      chk_bits("mid_err_pre", {1'b0, error}, 2'b01);
      do_reset("mid_rst");
      fl[8] = mk(1'b1, 1'b0, 4'd5, PL_W'(400));
      chan_in = fl[8];
      tick();
      chan_in = '0;
      chk_flit("mid_lat0", chan_out, zf);
      tick();
      chk_flit("mid_new_head", chan_out, fl[8]);
      chk_bits("mid_new_err", {1'b0, error}, 2'b00);
      tick();
      chk_flit("mid_fifo_empty", chan_out, zf);
      fc_in = 2'b10;
      tick();
      chk_bits("mid_cred_back", {1'b0, error}, 2'b00);
      tick();
      fc_in = 2'b00;
      chk_bits("mid_cred_full", {1'b0, error}, 2'b01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/router_slice_cb.md
# router_slice_cb

Parametrised, credit-flow-controlled successor to the single-register link slice. It sits on a NoC link between two router ports. Each flit is buffered in a DEPTH-entry FIFO and forwarded downstream only while downstream credits are available; one credit is returned upstream per flit forwarded. Per-packet framing is tracked, and a sticky ERROR flags protocol, overflow, credit and loopback violations.

## Interface
- FLIT_W, 68: flit width in bits; must be ≥ 3+ADDR_W.
- ADDR_W, 4: router address width.
- DEPTH, 4: input FIFO entries; ≥2, any integer.
- DOWN_CREDITS, 4: credits held at reset for the downstream buffer; ≥1.

- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ROUTER_ADDRESS  in  [0:ADDR_W-1]  this node's address; quasi-static.
- CHANNEL_IN_IP  in  [0:FLIT_W-1]  input flit. [0] valid, [1] head, [2] tail, [3:3+ADDR_W-1] destination (head only), rest payload.
- FLOW_CTRL_IN_OP  in  [0:1]  [0] credit return from downstream, one pulse per freed slot; [1] ignored.
- ERROR  out  1  sticky error flag.
- CHANNEL_OUT_OP  out  [0:FLIT_W-1]  output flit, same format.
- FLOW_CTRL_OUT_IP  out  [0:1]  [0] credit pulse to upstream; [1] always 0.

## Operation
- Reset (reset=0, async): FIFO empty, credit counter = DOWN_CREDITS, packet FSM = IDLE, ERROR=0, CHANNEL_OUT_OP=0, FLOW_CTRL_OUT_IP=0.
- Enqueue: any cycle with CHANNEL_IN_IP[0]=1, the whole flit is written to the FIFO, unless this is an overflow.
  - Overflow: occupancy==DEPTH and no dequeue in the same cycle.
  - On overflow the flit is dropped and ERROR is set.
  - Full with a same-cycle dequeue: the flit is accepted.
- Dequeue: a cycle with FIFO non-empty and credit counter >0.
  - The head entry is registered into CHANNEL_OUT_OP (valid=1) and FLOW_CTRL_OUT_IP[0] is registered to 1.
  - The credit counter decrements.
- Idle output: when no dequeue occurs, CHANNEL_OUT_OP and FLOW_CTRL_OUT_IP[0] register to all-zero.
- Credit counter: width clog2(DOWN_CREDITS+1).
  - FLOW_CTRL_IN_OP[0]=1 increments it.
  - Increment and dequeue in the same cycle: counter unchanged.
  - Increment when counter==DOWN_CREDITS with no dequeue: counter saturates and ERROR is set.
- Packet FSM (input side, evaluated on valid flits, including dropped ones):
  - IDLE, head&tail: stay IDLE (single-flit packet).
  - IDLE, head&!tail: go to ACTIVE.
  - IDLE, !head: set ERROR, stay IDLE.
  - ACTIVE, tail&!head: go to IDLE.
  - ACTIVE, head: set ERROR; next state = IDLE if tail, else ACTIVE.
  - ACTIVE, neither: stay ACTIVE.
- Loopback check: a valid head flit with destination == ROUTER_ADDRESS sets ERROR; the flit is still forwarded.
- ERROR: cleared only by reset. Errors never stall or alter forwarding, apart from the overflow drop.
- FIFO: circular buffer, pointers wrap modulo DEPTH; flit order is preserved.

## Timing
- Minimum latency 1 cycle: a flit presented at edge t appears on CHANNEL_OUT_OP after edge t+1, if credits >0 and the FIFO was empty.
- Throughput: 1 flit/cycle sustained while credits are available.
- Upstream credit pulse: asserted in the same cycle as the corresponding output flit; always exactly one cycle.
- Downstream credits returned at edge t are usable for a dequeue at edge t+1.
- ERROR rises at the edge that samples the violating input.
- Reset asserted mid-packet or mid-transfer: all outputs go to reset values immediately; buffered flits and credits are discarded.
- Reset release is synchronised externally; the first valid flit is sampled at the first edge after deassertion.

## Test plan
- Single-flit packet (valid, head, tail, dest=5, ROUTER_ADDRESS=3, payload 0xA5) -> after 1 cycle CHANNEL_OUT_OP carries an identical flit; FLOW_CTRL_OUT_IP[0]=1 for one cycle; ERROR=0.
- Credit exhaustion:
  - Stimulus: DOWN_CREDITS=4, no credit returns, send 6 flits back-to-back.
  - Response: exactly 4 flits output, 2 held in the FIFO.
  - Then pulse FLOW_CTRL_IN_OP[0] twice: remaining 2 flits emerge in order, one per cycle after each credit.
- Overflow: DEPTH=4, no credits returned, 9 consecutive flits -> flits 1-4 forwarded, 5-8 buffered, 9th dropped; ERROR=1 from that edge.
- Framing violations, each after a fresh reset:
  - Body flit while IDLE -> ERROR=1.
  - Head, head, tail sequence -> ERROR=1 at the second head; FSM returns to IDLE after the tail.
- Credit overflow and loopback, each after a fresh reset:
  - Credit return while the counter equals DOWN_CREDITS -> ERROR=1.
  - Head with dest==ROUTER_ADDRESS -> ERROR=1 and the flit is still forwarded.
- Reset mid-packet: assert reset while 3 flits are buffered -> outputs zero immediately; after release, credits=DOWN_CREDITS, FIFO empty, and a new head is accepted without error.
